// File: rtl/tlp2mdio_if.sv
// TRN receive-stream bundle as seen by a passive tap: the source drives every
// signal, including the real consumer's destination-ready, and the tap only listens.
interface tlp2mdio_if;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rdst_rdy_n;
  logic [6:0]  trn_rbar_hit_n;

  modport master (
    output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
           trn_rsrc_rdy_n, trn_rdst_rdy_n, trn_rbar_hit_n
  );

  modport slave (
    input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n,
           trn_rsrc_rdy_n, trn_rdst_rdy_n, trn_rbar_hit_n
  );
endinterface

// File: rtl/tlp2mdio.sv
// Passive TRN RX tap: catches single-DW MWr32 to the MDIO access register and
// holds the byte-swapped command on acc_data/acc_en until the host acknowledges it.
module tlp2mdio #(
  parameter int          BAR_IDX    = 0,
  parameter logic [11:0] REG_OFFSET = 12'h040
) (
  input  logic              trn_clk,
  input  logic              trn_reset_n,
  tlp2mdio_if.slave         rx,
  output logic [31:0]       acc_data,
  output logic              acc_en,
  input  logic              acc_en_ack,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PEND} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_pend_hdr, w_pend_hdr_nxt;
  logic [3:0]  r_be, w_be_nxt;
  logic        r_ack_p0, r_ack_p1, r_ack_p2;
  logic        w_beat, w_hdr_match, w_hdr_cur, w_hdr_nxt, w_pend, w_pend_nxt;
  logic        w_addr_match, w_data_ok, w_capture, w_drop, w_ack_edge;
  logic        w_unused;

  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign w_beat      = !rx.trn_rsrc_rdy_n && !rx.trn_rdst_rdy_n;
  assign w_hdr_match = (rx.trn_rd[62:61] == 2'b10) && (rx.trn_rd[60:56] == 5'b00000) &&
                       (rx.trn_rd[41:32] == 10'd1) && !rx.trn_rbar_hit_n[BAR_IDX];
  assign w_pend      = (r_state == S_PEND);
  // A header may be outstanding either in HDR or while a command is still pending.
  assign w_hdr_cur   = (r_state == S_HDR) || (w_pend && r_pend_hdr);
  assign w_addr_match = (rx.trn_rd[43:34] == REG_OFFSET[11:2]);
  assign w_data_ok   = !rx.trn_reof_n && (rx.trn_rrem_n == 8'h00) && (r_be == 4'hF);
  assign w_ack_edge  = r_ack_p1 && !r_ack_p2;
  assign w_unused    = ^{rx.trn_rd[63], rx.trn_rd[55:44], rx.trn_rbar_hit_n};

  always_comb begin
    w_hdr_nxt = w_hdr_cur;
    w_be_nxt  = r_be;
    w_capture = 1'b0;
    w_drop    = 1'b0;
    if (w_beat) begin
      if (!rx.trn_rsof_n) begin
        w_hdr_nxt = w_hdr_match;
        w_be_nxt  = rx.trn_rd[3:0];
      end else if (w_hdr_cur) begin
        w_hdr_nxt = 1'b0;
        if (w_addr_match) begin
          if (w_data_ok && !w_pend) w_capture = 1'b1;
          else                      w_drop    = 1'b1;
        end
      end
    end
    // Ack beats a simultaneous write: the write was already counted as a drop above.
    w_pend_nxt     = w_capture || (w_pend && !w_ack_edge);
    w_pend_hdr_nxt = w_pend_nxt && w_hdr_nxt;
    if (w_pend_nxt)     w_state_nxt = S_PEND;
    else if (w_hdr_nxt) w_state_nxt = S_HDR;
    else                w_state_nxt = S_IDLE;
  end

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_state    <= S_IDLE;
      r_pend_hdr <= 1'b0;
      acc_en     <= 1'b0;
      acc_data   <= 32'h0;
      drop_cnt   <= 8'h0;
      r_ack_p0   <= 1'b0;
      r_ack_p1   <= 1'b0;
      r_ack_p2   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_hdr <= w_pend_hdr_nxt;
      acc_en     <= w_pend_nxt;
      if (w_capture) acc_data <= swap_bytes(rx.trn_rd[31:0]);
      if (w_drop)    drop_cnt <= sat_inc(drop_cnt);
      r_ack_p0   <= acc_en_ack;
      r_ack_p1   <= r_ack_p0;
      r_ack_p2   <= r_ack_p1;
    end
  end

  always_ff @(posedge trn_clk) begin
    r_be <= w_be_nxt;
  end

endmodule

// File: doc/tlp2mdio.md
Name: tlp2mdio

Overview:
- Passive tap on the 64-bit PCIe TRN receive stream in the trn_clk domain.
- Detects single-DW 32-bit-address memory writes to the MDIO access register in a selected BAR, and extracts the 32-bit payload.
- Presents the payload as acc_data/acc_en, held until the host-clock MDIO host-interface FSM returns acc_en_ack.
- Feeds the MDIO host-interface stage. It never back-pressures the TRN stream.

Parameters:
- BAR_IDX, 0: index into trn_rbar_hit_n selecting the BAR that owns the MDIO register.
- REG_OFFSET, 12'h040: byte offset of the MDIO access register within the BAR. Compared on address bits [11:2].

Ports:
- trn_clk  in  1  PCIe user clock; all logic on rising edge.
- trn_reset_n  in  1  reset, asynchronous assert, active-low.
- trn_rd  in  64  RX data; [63:32] is the earlier DW.
- trn_rrem_n  in  8  RX remainder; 8'h0F means only [63:32] is valid.
- trn_rsof_n  in  1  start of TLP, active-low.
- trn_reof_n  in  1  end of TLP, active-low.
- trn_rsrc_rdy_n  in  1  source ready, active-low.
- trn_rdst_rdy_n  in  1  destination ready driven by the real consumer; monitored only.
- trn_rbar_hit_n  in  7  BAR hit, active-low, valid on the SOF beat.
- acc_data  out  32  MDIO command word, byte-swapped to host order.
- acc_en  out  1  level; command pending.
- acc_en_ack  in  1  host_clk-domain pulse; command taken.
- drop_cnt  out  8  saturating count of matching writes dropped while busy or malformed.

Behaviour:
- A beat is accepted when trn_rsrc_rdy_n=0 and trn_rdst_rdy_n=0. Non-accepted cycles are ignored in every state.
- Reset (trn_reset_n=0, asynchronous): acc_data=0, acc_en=0, drop_cnt=0, FSM=IDLE, ack synchroniser flops=0. Reset mid-command discards the command; no ack is awaited after release.
- Header match on the SOF beat, all of the following:
  - trn_rd[62:61]=2'b10 (3DW with data)
  - trn_rd[60:56]=5'b00000 (MWr)
  - trn_rd[41:32]=10'd1 (length)
  - trn_rbar_hit_n[BAR_IDX]=0
- FSM states: IDLE, HDR, PEND.
  - IDLE: on an accepted beat with sof=0 and header match, latch first-DW byte enables trn_rd[3:0] and go to HDR. A non-matching SOF stays in IDLE.
  - HDR, next accepted beat:
    - trn_rd[63:32] is the address; trn_rd[31:0] is the data.
    - Valid beat: trn_reof_n=0, trn_rrem_n=8'h00, addr[11:2]=REG_OFFSET[11:2], first BE=4'hF.
      - If valid: acc_data <= {d[7:0],d[15:8],d[23:16],d[31:24]}, acc_en <= 1, go to PEND. acc_en rises the cycle after the data beat is accepted.
      - If the address mismatches: go to IDLE silently.
      - If the address matches but BE≠F or the eof/rrem check fails: drop_cnt++ and go to IDLE.
    - An accepted sof=0 beat while in HDR means a malformed/aborted TLP. Restart header evaluation on that beat; no drop.
  - PEND: acc_en and acc_data are held stable. Header parsing continues. Each fully matching write that completes while in PEND increments drop_cnt and does not modify acc_data.
- Ack synchronisation: acc_en_ack passes through two flops into the trn_clk domain, followed by rising-edge detection.
  - On a detected edge in PEND: acc_en <= 0 and the FSM goes to IDLE. acc_en falls 3 cycles after the ack edge arrives at the first flop.
  - An ack edge detected outside PEND is ignored.
- Simultaneous events: if an ack edge and a new valid data beat occur in the same cycle in PEND, the ack wins. The new write counts as dropped; it is not queued.
- drop_cnt saturates at 8'hFF and does not wrap.
- acc_en is glitch-free: a direct register output, no combinational path from inputs.

Test Plan:
- Valid write: MWr32, length 1, BAR0 hit, addr 0x...040, BE F, data bytes 78 56 34 12 on trn_rd[31:0] = 32'h78563412 → acc_data=32'h12345678, acc_en=1 one cycle after the data beat; ack pulse → acc_en=0 three cycles later.
- Filters: write to offset 0x044, a BAR1 hit, a length-2 write, and a 4DW (fmt 11) write → acc_en stays 0, drop_cnt stays 0.
- Busy drop: a second valid write while acc_en=1 with a different payload → acc_data unchanged, drop_cnt=1; after ack, a third write is captured normally.
- Malformed: header match with BE=4'h3 → drop_cnt=1, no acc_en. SOF asserted in HDR → the new TLP is parsed and captured if valid.
- Stall/saturation: insert trn_rsrc_rdy_n=1 and trn_rdst_rdy_n=1 gaps between the header and data beats → capture still correct. 300 busy drops → drop_cnt=8'hFF.
- Reset: assert trn_reset_n low while in PEND → acc_en=0 and acc_data=0 immediately (asynchronous); a late ack after release has no effect.
